// File: rtl/ring_pattern_checker_if.sv
// Ring checker bus: sample strobe and ring value in, position/status/error out.
interface ring_pattern_checker_if #(
  parameter int WIDTH = 4
);
  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             sample_i;
  logic [WIDTH-1:0] ring_i;
  logic [PW-1:0]    pos_o;
  logic             valid_o;
  logic             locked_o;
  logic             err_o;
  logic [7:0]       err_count_o;

  // Source side: drives the ring sample, observes checker status.
  modport master (
    output sample_i,
    output ring_i,
    input  pos_o,
    input  valid_o,
    input  locked_o,
    input  err_o,
    input  err_count_o
  );

  // Checker side.
  modport slave (
    input  sample_i,
    input  ring_i,
    output pos_o,
    output valid_o,
    output locked_o,
    output err_o,
    output err_count_o
  );
endinterface

// File: rtl/ring_pattern_checker.sv
// Receive-side checker for a rotating one-hot ring bus. Each strobed sample
// must be the one-position left rotation of the previously accepted sample.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no valid reference sample; waiting for a one-hot value
//   TRACK  | reference held, counting consecutive correct rotations
//   LOCKED | LOCK_COUNT rotations seen in a row; ring considered healthy
module ring_pattern_checker #(
  parameter int WIDTH      = 4,
  parameter int LOCK_COUNT = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  ring_pattern_checker_if.slave bus
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (LOCK_COUNT > 0) ? $clog2(LOCK_COUNT + 1) : 1;

  localparam logic [CW-1:0] LOCK_TARGET = CW'(LOCK_COUNT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRACK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [PW-1:0]    pos_q, pos_d;
  logic [CW-1:0]    match_q, match_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;

  logic             is_zero;
  logic             is_onehot;
  logic             is_multi;
  logic             is_rot;
  logic             is_reload;
  logic [PW-1:0]    ring_idx;
  logic [WIDTH-1:0] rot_prev;
  logic [CW-1:0]    match_inc;

  // Classify the incoming sample and locate its set bit.
  always_comb begin
    is_zero   = (bus.ring_i == '0);
    is_onehot = !is_zero && ((bus.ring_i & (bus.ring_i - WIDTH'(1))) == '0);
    is_multi  = !is_zero && !is_onehot;
    ring_idx  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.ring_i[i]) ring_idx = PW'(i);
    end
  end

  // Compare against the expected rotation of the last accepted sample.
  always_comb begin
    rot_prev  = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
    is_rot    = (bus.ring_i == rot_prev);
    is_reload = (bus.ring_i == WIDTH'(1));
    match_inc = match_q + CW'(1);
  end

  // Next-state and error decision, evaluated only on strobe cycles.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    pos_d   = pos_q;
    match_d = match_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (bus.sample_i) begin
      case (state_q)
        ST_IDLE: begin
          if (is_onehot) begin
            prev_d  = bus.ring_i;
            pos_d   = ring_idx;
            match_d = '0;
            state_d = ST_TRACK;
          end else if (is_multi) begin
            err_d = 1'b1;
          end
        end

        ST_TRACK: begin
          if (is_onehot && is_rot) begin
            prev_d = bus.ring_i;
            pos_d  = ring_idx;
            if (match_inc == LOCK_TARGET) begin
              match_d = '0;
              state_d = ST_LOCKED;
            end else begin
              match_d = match_inc;
            end
          end else if (is_onehot) begin
            // Fresh one-hot start point; not treated as a fault.
            prev_d  = bus.ring_i;
            pos_d   = ring_idx;
            match_d = '0;
          end else begin
            state_d = ST_IDLE;
            err_d   = is_multi;
          end
        end

        ST_LOCKED: begin
          if (is_onehot && is_rot) begin
            prev_d = bus.ring_i;
            pos_d  = ring_idx;
          end else if (is_onehot) begin
            // A jump back to bit 0 is the ring reloading; anything else is a skip.
            prev_d  = bus.ring_i;
            pos_d   = ring_idx;
            match_d = '0;
            state_d = ST_TRACK;
            err_d   = !is_reload;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end

        default: begin
          state_d = ST_IDLE;
          match_d = '0;
        end
      endcase
    end

    if (err_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
      pos_q   <= '0;
      match_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      pos_q   <= pos_d;
      match_q <= match_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pos_o       = pos_q;
  assign bus.valid_o     = (state_q != ST_IDLE);
  assign bus.locked_o    = (state_q == ST_LOCKED);
  assign bus.err_o       = err_q;
  assign bus.err_count_o = cnt_q;

endmodule
